multicycle_control: RTL and testbench

Main control FSM for the multicycle RV32I core: sequences fetch, decode, execute, memory and write-back for one instruction at a time. It drives the shared ALU's operand muxes and `alu_op` (consumed by the ALU control decoder), the register-file, PC and IR write enables, and a single-port memory request/ready handshake. It sits between the instruction register and the datapath muxes.

---
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core: runs fetch/decode/execute/
// memory/write-back for one instruction at a time over a shared ALU and memory port.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_JALR_PC  = 4'd11,
    S_BRANCH   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t cur, nxt;

  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  assign state = cur;

  // Reset overrides the whole decode so an abandoned instruction issues no writes.
  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (cur)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          case (opcode)
            OP_LOAD, OP_STORE: nxt = S_MEMADR;
            OP_R:              nxt = S_EXEC_R;
            OP_I:              nxt = S_EXEC_I;
            OP_BRANCH:         nxt = S_BRANCH;
            OP_JAL:            nxt = S_JAL;
            OP_JALR:           nxt = S_JALR;
            OP_LUI:            nxt = S_LUI;
            OP_AUIPC:          nxt = S_AUIPC;
            OP_FENCE: begin
              nxt        = S_FETCH;
              instr_done = 1'b1;
            end
            default:           nxt = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          nxt       = opcode[5] ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) nxt = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
          nxt       = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b11;
          nxt       = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 2'b10;
          alu_op     = 2'b01;
          pc_write   = branch_taken;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_JAL, S_JALR_PC: begin
          // ALUOut already holds the jump target; the ALU forms oldPC+4 for rd.
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
          nxt       = S_ALU_WB;
        end
        S_JALR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          nxt       = S_JALR_PC;
        end
        S_LUI: begin
          alu_src_a = 2'b11;
          alu_src_b = 2'b01;
          nxt       = S_ALU_WB;
        end
        S_AUIPC: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          nxt       = S_ALU_WB;
        end
        S_TRAP: begin
          illegal = 1'b1;
          nxt     = S_TRAP;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-instruction trace model
// built from the sequencing rules is compared cycle by cycle with the DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       instr_done, illegal;
  logic [3:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, instr_done, illegal};

  // Expected trace: one entry per cycle, plus the mem_ready value to drive.
  logic [3:0]  exp_st[$];
  logic [15:0] exp_ctl[$];
  bit          drv_mr[$];

  function automatic logic [15:0] mk(bit rq, bit we, bit ad, bit iw, bit pw, bit rw,
                                     logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                     logic [1:0] op, bit dn, bit il);
    return {rq, we, ad, iw, pw, rw, rs, a, b, op, dn, il};
  endfunction

  task automatic push(logic [3:0] st, logic [15:0] c, bit mr);
    exp_st.push_back(st);
    exp_ctl.push_back(c);
    drv_mr.push_back(mr);
  endtask

  // Builds the cycle-by-cycle expectation of one whole instruction.
  task automatic build_instr(logic [6:0] opc, int fw, int mw, bit bt, int trap_cycles);
    bit fence;
    fence = (opc == 7'b0001111);
    for (int i = 0; i < fw; i++) push(0, mk(1,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,0,0), 1'b0);
    push(0, mk(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,0,0), 1'b1);
    push(1, mk(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,fence,0), 1'($urandom));
    case (opc)
      7'b0000011: begin
        push(2, mk(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,0,0), 1'($urandom));
        for (int i = 0; i < mw; i++) push(3, mk(1,0,1,0,0,0,0,0,0,0,0,0), 1'b0);
        push(3, mk(1,0,1,0,0,0,0,0,0,0,0,0), 1'b1);
        push(4, mk(0,0,0,0,0,1,2'd1,0,0,0,1,0), 1'($urandom));
      end
      7'b0100011: begin
        push(2, mk(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,0,0), 1'($urandom));
        for (int i = 0; i < mw; i++) push(5, mk(1,1,1,0,0,0,0,0,0,0,0,0), 1'b0);
        push(5, mk(1,1,1,0,0,0,0,0,0,0,1,0), 1'b1);
      end
      7'b0110011: begin
        push(6, mk(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,0,0), 1'($urandom));
        push(8, mk(0,0,0,0,0,1,0,0,0,0,1,0), 1'($urandom));
      end
      7'b0010011: begin
        push(7, mk(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd3,0,0), 1'($urandom));
        push(8, mk(0,0,0,0,0,1,0,0,0,0,1,0), 1'($urandom));
      end
      7'b1100011:
        push(12, mk(0,0,0,0,bt,0,2'd0,2'd2,2'd0,2'd1,1,0), 1'($urandom));
      7'b1101111: begin
        push(9, mk(0,0,0,0,1,0,2'd0,2'd1,2'd2,2'd0,0,0), 1'($urandom));
        push(8, mk(0,0,0,0,0,1,0,0,0,0,1,0), 1'($urandom));
      end
      7'b1100111: begin
        push(10, mk(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,0,0), 1'($urandom));
        push(11, mk(0,0,0,0,1,0,2'd0,2'd1,2'd2,2'd0,0,0), 1'($urandom));
        push(8, mk(0,0,0,0,0,1,0,0,0,0,1,0), 1'($urandom));
      end
      7'b0110111: begin
        push(13, mk(0,0,0,0,0,0,2'd0,2'd3,2'd1,2'd0,0,0), 1'($urandom));
        push(8, mk(0,0,0,0,0,1,0,0,0,0,1,0), 1'($urandom));
      end
      7'b0010111: begin
        push(14, mk(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,0), 1'($urandom));
        push(8, mk(0,0,0,0,0,1,0,0,0,0,1,0), 1'($urandom));
      end
      7'b0001111: ;
      default:
        for (int i = 0; i < trap_cycles; i++) push(15, mk(0,0,0,0,0,0,0,0,0,0,0,1), 1'($urandom));
    endcase
  endtask

  // All tasks start and end at posedge+1 of the cycle about to be checked.
  task automatic test_reset;
    int n;
    rst = 1'b1; opcode = 7'b0000011; mem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      #1; n_chk++;
      if (obs !== 16'h0) begin
        n_fail++; $display("FAIL reset_init cyc %0d: ctl=%h want %h", k, obs, 16'h0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    build_instr(7'b0000011, 0, 6, 1'b0, 0);
    n = 5;  // FETCH, DECODE, MEMADR, two MEMREAD wait cycles
    for (int k = 0; k < n; k++) begin
      mem_ready = drv_mr.pop_front(); #1;
      n_chk++;
      if (state !== exp_st[0] || obs !== exp_ctl[0]) begin
        n_fail++;
        $display("FAIL reset_pre cyc %0d: state=%0d ctl=%h want state=%0d ctl=%h",
                 k, state, obs, exp_st[0], exp_ctl[0]);
      end
      void'(exp_st.pop_front()); void'(exp_ctl.pop_front());
      @(posedge clk); #1;
    end
    exp_st.delete(); exp_ctl.delete(); drv_mr.delete();
    rst = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1; n_chk++;
      if (obs !== 16'h0) begin
        n_fail++; $display("FAIL reset_mid cyc %0d: ctl=%h want %h", k, obs, 16'h0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_ready = 1'b0; #1;
    n_chk++;
    if (state !== 4'd0 || mem_req !== 1'b1 || pc_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d mem_req=%b pc_write=%b want 0 1 0",
               state, mem_req, pc_write);
    end
  endtask

  task automatic test_add;
    int n;
    opcode = 7'b0110011;
    build_instr(opcode, 0, 0, 1'b0, 0);
    n = exp_st.size();
    for (int k = 0; k < n; k++) begin
      mem_ready = drv_mr.pop_front(); #1;
      n_chk++;
      if (state !== exp_st[0] || obs !== exp_ctl[0]) begin
        n_fail++;
        $display("FAIL add cyc %0d: state=%0d ctl=%h want state=%0d ctl=%h",
                 k, state, obs, exp_st[0], exp_ctl[0]);
      end
      void'(exp_st.pop_front()); void'(exp_ctl.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait;
    int n;
    opcode = 7'b0000011;
    build_instr(opcode, 0, 3, 1'b0, 0);
    n = exp_st.size();
    for (int k = 0; k < n; k++) begin
      mem_ready = drv_mr.pop_front(); #1;
      n_chk++;
      if (state !== exp_st[0] || obs !== exp_ctl[0]) begin
        n_fail++;
        $display("FAIL lw_wait cyc %0d: state=%0d ctl=%h want state=%0d ctl=%h",
                 k, state, obs, exp_st[0], exp_ctl[0]);
      end
      void'(exp_st.pop_front()); void'(exp_ctl.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    int n;
    opcode = 7'b1100011;
    for (int t = 0; t < 2; t++) begin
      branch_taken = (t == 0);
      build_instr(opcode, 0, 0, branch_taken, 0);
      n = exp_st.size();
      for (int k = 0; k < n; k++) begin
        mem_ready = drv_mr.pop_front(); #1;
        n_chk++;
        if (state !== exp_st[0] || obs !== exp_ctl[0]) begin
          n_fail++;
          $display("FAIL beq_taken%0d cyc %0d: state=%0d ctl=%h want state=%0d ctl=%h",
                   branch_taken, k, state, obs, exp_st[0], exp_ctl[0]);
        end
        void'(exp_st.pop_front()); void'(exp_ctl.pop_front());
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jalr;
    int n;
    opcode = 7'b1100111;
    build_instr(opcode, 0, 0, 1'b0, 0);
    n = exp_st.size();
    for (int k = 0; k < n; k++) begin
      mem_ready = drv_mr.pop_front(); #1;
      n_chk++;
      if (state !== exp_st[0] || obs !== exp_ctl[0]) begin
        n_fail++;
        $display("FAIL jalr cyc %0d: state=%0d ctl=%h want state=%0d ctl=%h",
                 k, state, obs, exp_st[0], exp_ctl[0]);
      end
      void'(exp_st.pop_front()); void'(exp_ctl.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random_mix;
    logic [6:0] ops [10];
    int n;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
    for (int i = 0; i < 40; i++) begin
      opcode       = ops[$urandom_range(9)];
      branch_taken = 1'($urandom);
      build_instr(opcode, $urandom_range(3), $urandom_range(3), branch_taken, 0);
      n = exp_st.size();
      for (int k = 0; k < n; k++) begin
        mem_ready = drv_mr.pop_front(); #1;
        n_chk++;
        if (state !== exp_st[0] || obs !== exp_ctl[0]) begin
          n_fail++;
          $display("FAIL mix op=%b cyc %0d: state=%0d ctl=%h want state=%0d ctl=%h",
                   opcode, k, state, obs, exp_st[0], exp_ctl[0]);
        end
        void'(exp_st.pop_front()); void'(exp_ctl.pop_front());
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_trap;
    int n;
    opcode = 7'b1110011;
    build_instr(opcode, 1, 0, 1'b0, 10);
    n = exp_st.size();
    for (int k = 0; k < n; k++) begin
      mem_ready = drv_mr.pop_front(); #1;
      n_chk++;
      if (state !== exp_st[0] || obs !== exp_ctl[0]) begin
        n_fail++;
        $display("FAIL trap cyc %0d: state=%0d ctl=%h want state=%0d ctl=%h",
                 k, state, obs, exp_st[0], exp_ctl[0]);
      end
      void'(exp_st.pop_front()); void'(exp_ctl.pop_front());
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    n_chk++;
    if (obs !== 16'h0) begin
      n_fail++; $display("FAIL trap_rst: ctl=%h want %h", obs, 16'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0; #1;
    n_chk++;
    if (state !== 4'd0 || mem_req !== 1'b1 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_exit: state=%0d mem_req=%b illegal=%b want 0 1 0",
               state, mem_req, illegal);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_load_wait;
    test_branch;
    test_jalr;
    test_random_mix;
    test_trap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
